dmem_responder: RTL

Memory-side responder for the core's load/store traffic: accepts one request at a time over a valid/ready handshake and completes it after a fixed, parameterised latency. Store sizes and load sign-extension follow the RISC-V func3 encoding carried by the memory stage. Misaligned, out-of-range and undefined-func3 accesses are reported with an error flag. It is the slave end of the data-memory port, so the pipeline can be exercised against realistic multi-cycle memory timing.

---
 rtl/dmem_if.sv | 31 +++
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_if
// Brief    : Data-memory request/response port (valid/ready both directions).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_func3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_func3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_func3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory slave with RISC-V sized/signed access.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    dmem_if.slave     bus
);
    localparam int         c_WORDS    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_exec;

    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [2:0]            r_func3;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] r_mem [0:c_WORDS-1];

    logic                  w_func_bad;
    logic                  w_misalign;
    logic                  w_out_of_range;
    logic                  w_err;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_store_lanes;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_exec         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_exec       = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // --------------------------------------------------------- access checks
    always_comb begin
        case (r_func3)
            3'b000, 3'b001, 3'b010: w_func_bad = 1'b0;
            3'b100, 3'b101:         w_func_bad = r_write;  // unsigned forms are load-only
            default:                w_func_bad = 1'b1;
        endcase
        w_misalign     = ((r_func3[1:0] == 2'b01) && r_addr[0]) ||
                         ((r_func3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
        w_out_of_range = |r_addr[DATA_WIDTH-1:ADDR_WIDTH];
        w_err          = w_func_bad | w_misalign | w_out_of_range;
    end

    // ---------------------------------------------------------- store lanes
    always_comb begin
        case (r_func3[1:0])
            2'b00: begin
                w_be          = 4'b0001 << r_addr[1:0];
                w_store_lanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be          = r_addr[1] ? 4'b1100 : 4'b0011;
                w_store_lanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be          = 4'b1111;
                w_store_lanes = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_exec && r_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= w_store_lanes[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------- load extend
    always_comb begin
        w_word    = r_mem[r_addr[ADDR_WIDTH-1:2]];
        w_shifted = w_word >> {r_addr[1:0], 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_func3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    // ------------------------------------------------ request latch/response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_func3 <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= bus.req_write;
                r_func3 <= bus.req_func3;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_cnt   <= c_CNT_INIT;
            end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_exec) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_write) ? '0 : w_load;
            end
        end
    end

    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

endmodule
`default_nettype wire
